// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and default sizing for the fetch/data memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - grant_e     : which requester received the most recent grant
//   - *_DEF       : default TIMEOUT / ADDR_W / DATA_W parameter values
package mem_arb_pkg;

    localparam int TIMEOUT_DEF = 16;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter
//   Wait-cycle counter with synchronous clear, count enable and a
//   terminal-count strobe.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     clr_i        : return count to zero (has priority over en_i)
//     en_i         : count one more waiting cycle
//     tc_o         : high in the enabled cycle that brings the count to MAX
module arb_wait_counter #(
    parameter int MAX = 16,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)
            count <= '0;
        else if (en_i && count != W'(MAX))
            count <= count + W'(1);
    end

    // Strobe on the cycle that would make the count reach MAX, so the
    // caller can act on that same edge.
    assign tc_o = en_i && (count == W'(MAX - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port and a data port onto one
//   unified memory port, with a wait timeout that still acks the requester.
//   Ports:
//     clk_i, rst_i             : clock, synchronous active-high reset
//     if_req_i/if_addr_i       : fetch request (level) and address
//     if_rdata_o/if_ack_o      : fetched word and one-cycle completion
//     d_req_i/d_we_i/d_addr_i/d_wdata_i : data request, direction, addr, wdata
//     d_rdata_o/d_ack_o        : read data and one-cycle completion
//     stall_o                  : pipeline freeze while any request is open
//     mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : memory request bus
//     mem_rdata_i/mem_ready_i  : memory read data and one-cycle completion
//     err_o                    : sticky timeout flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o
);

    arb_state_e state, state_nxt;
    grant_e     last_grant;
    logic       grant_d, grant_i, busy, wait_tc;

    // Data wins by default; fetch wins only when data had the last grant
    // and a fetch is waiting, so neither side can starve the other.
    assign grant_d = (state == IDLE) && d_req_i &&
                     !(last_grant == GRANT_D && if_req_i);
    assign grant_i = (state == IDLE) && if_req_i && !grant_d;
    assign busy    = (state == BUSY_I) || (state == BUSY_D);

    arb_wait_counter #(.MAX(TIMEOUT)) u_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (grant_d || grant_i),
        .en_i  (busy && !mem_ready_i),
        .tc_o  (wait_tc)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = BUSY_D;
                else if (grant_i) state_nxt = BUSY_I;
            end
            BUSY_I: if (mem_ready_i || wait_tc) state_nxt = DONE_I;
            BUSY_D: if (mem_ready_i || wait_tc) state_nxt = DONE_D;
            DONE_I: state_nxt = IDLE;
            DONE_D: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        mem_req_o = busy;
        if_ack_o  = (state == DONE_I);
        d_ack_o   = (state == DONE_D);
    end

    assign stall_o = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);

    // Request bus capture, read data latching, grant history and error flag.
    // A timeout latches zero so the requester sees a defined word with its ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            last_grant  <= GRANT_I;
            err_o       <= 1'b0;
        end else begin
            if (grant_d) begin
                mem_we_o    <= d_we_i;
                mem_addr_o  <= d_addr_i;
                mem_wdata_o <= d_wdata_i;
                last_grant  <= GRANT_D;
            end else if (grant_i) begin
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
                last_grant  <= GRANT_I;
            end

            if (busy && (mem_ready_i || wait_tc)) begin
                mem_we_o <= 1'b0;
                if (!mem_ready_i) err_o <= 1'b1;
                if (state == BUSY_I)
                    if_rdata_o <= mem_ready_i ? mem_rdata_i : '0;
                else
                    d_rdata_o  <= mem_ready_i ? mem_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              d_req_i, d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i, d_rdata_o;
    logic              d_ack_o, stall_o;
    logic              mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
    logic              mem_ready_i, err_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(16), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .err_o(err_o)
    );

    // Advance one clock and settle; checks happen here, inputs change after.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o, stall_o} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000000",
                              {mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o, stall_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o} !== '0) begin
            fails++; $display("FAIL reset_bus: addr %h wdata %h ir %h dr %h want 0",
                              mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    // Fetch, ready two cycles after mem_req_o: ack four cycles after request.
    task automatic test_fetch();
        if_req_i = 1'b1; if_addr_i = 32'h40;
        tick();
        checks++;
        if ({mem_req_o, mem_we_o, stall_o} !== 3'b101 || mem_addr_o !== 32'h40) begin
            fails++; $display("FAIL fetch_issue: req/we/stall %b addr %h want 101 00000040",
                              {mem_req_o, mem_we_o, stall_o}, mem_addr_o);
        end
        tick();
        tick();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h8C010004;
        checks++;
        if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1) begin
            fails++; $display("FAIL fetch_wait: ack %b req %b want 0 1", if_ack_o, mem_req_o);
        end
        tick();
        mem_ready_i = 1'b0;
        checks++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h8C010004 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            fails++; $display("FAIL fetch_ack: ack %b rdata %h req %b stall %b want 1 8c010004 0 0",
                              if_ack_o, if_rdata_o, mem_req_o, stall_o);
        end
        if_req_i = 1'b0;
        tick();
        checks++;
        if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h8C010004) begin
            fails++; $display("FAIL fetch_hold: ack %b rdata %h want 0 8c010004", if_ack_o, if_rdata_o);
        end
    endtask

    // Both rise with last grant = fetch: data first, then fetch.
    task automatic test_arbitration();
        if_req_i = 1'b1; if_addr_i = 32'h44;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_wdata_i = 32'h0;
        tick();
        checks++;
        if (mem_addr_o !== 32'h200 || mem_req_o !== 1'b1 || stall_o !== 1'b1) begin
            fails++; $display("FAIL arb_data_first: addr %h req %b stall %b want 00000200 1 1",
                              mem_addr_o, mem_req_o, stall_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000D0D0;
        tick();
        mem_ready_i = 1'b0;
        checks++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h0000D0D0 || stall_o !== 1'b1) begin
            fails++; $display("FAIL arb_data_ack: ack %b rdata %h stall %b want 1 0000d0d0 1",
                              d_ack_o, d_rdata_o, stall_o);
        end
        d_req_i = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_addr_o !== 32'h44 || mem_req_o !== 1'b1 || stall_o !== 1'b1) begin
            fails++; $display("FAIL arb_fetch_second: addr %h req %b stall %b want 00000044 1 1",
                              mem_addr_o, mem_req_o, stall_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h00001111;
        tick();
        mem_ready_i = 1'b0;
        checks++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h00001111 || stall_o !== 1'b0) begin
            fails++; $display("FAIL arb_fetch_ack: ack %b rdata %h stall %b want 1 00001111 0",
                              if_ack_o, if_rdata_o, stall_o);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    // Two data writes with fetch held: fetch slots in between.
    task automatic test_back_to_back();
        if_req_i = 1'b1; if_addr_i = 32'h48;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'h11111111;
        tick();
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'h11111111) begin
            fails++; $display("FAIL b2b_write1: we %b addr %h wdata %h want 1 00000100 11111111",
                              mem_we_o, mem_addr_o, mem_wdata_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000AAAA;
        tick();
        mem_ready_i = 1'b0;
        checks++;
        if (d_ack_o !== 1'b1) begin
            fails++; $display("FAIL b2b_ack1: ack %b want 1", d_ack_o);
        end
        d_addr_i = 32'h104; d_wdata_i = 32'h22222222;
        tick();
        tick();
        checks++;
        if (mem_addr_o !== 32'h48 || mem_we_o !== 1'b0 || mem_req_o !== 1'b1) begin
            fails++; $display("FAIL b2b_fetch_between: addr %h we %b req %b want 00000048 0 1",
                              mem_addr_o, mem_we_o, mem_req_o);
        end
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        if_req_i = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h104 || mem_wdata_o !== 32'h22222222) begin
            fails++; $display("FAIL b2b_write2: we %b addr %h wdata %h want 1 00000104 22222222",
                              mem_we_o, mem_addr_o, mem_wdata_o);
        end
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        d_req_i = 1'b0;
        tick();
    endtask

    // A fetch raised and withdrawn while data is busy is never granted.
    task automatic test_withdraw();
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h180;
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h4C;
        tick();
        if_req_i = 1'b0;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h00000077;
        tick();
        mem_ready_i = 1'b0;
        checks++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h00000077) begin
            fails++; $display("FAIL withdraw_data_ack: ack %b rdata %h want 1 00000077", d_ack_o, d_rdata_o);
        end
        d_req_i = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_req_o !== 1'b0 || if_ack_o !== 1'b0 || stall_o !== 1'b0) begin
            fails++; $display("FAIL withdraw_dropped: req %b ack %b stall %b want 0 0 0",
                              mem_req_o, if_ack_o, stall_o);
        end
    endtask

    // No ready: 16 BUSY cycles, then ack with zero data and sticky error.
    task automatic test_timeout();
        int n = 0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
        mem_rdata_i = 32'h55555555;
        tick();
        checks++;
        if (err_o !== 1'b0 || mem_req_o !== 1'b1) begin
            fails++; $display("FAIL timeout_start: err %b req %b want 0 1", err_o, mem_req_o);
        end
        while (mem_req_o === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16) begin
            fails++; $display("FAIL timeout_cycles: busy %0d want 16", n);
        end
        checks++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h0 || err_o !== 1'b1) begin
            fails++; $display("FAIL timeout_ack: ack %b rdata %h err %b want 1 00000000 1",
                              d_ack_o, d_rdata_o, err_o);
        end
        d_req_i = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (err_o !== 1'b1 || d_ack_o !== 1'b0) begin
            fails++; $display("FAIL timeout_sticky: err %b ack %b want 1 0", err_o, d_ack_o);
        end
    endtask

    // Reset while BUSY_D: request drops, late ready ignored, data wins next.
    task automatic test_reset_mid();
        bit seen_ack = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h400) begin
            fails++; $display("FAIL rstmid_busy: req %b addr %h want 1 00000400", mem_req_o, mem_addr_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        d_req_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || err_o !== 1'b0 || if_rdata_o !== 32'h0 || d_ack_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_clear: req %b err %b ir %h ack %b want 0 0 00000000 0",
                              mem_req_o, err_o, if_rdata_o, d_ack_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (d_ack_o !== 1'b0 || if_ack_o !== 1'b0 || mem_req_o !== 1'b0) seen_ack = 1'b1;
            tick();
        end
        checks++;
        if (seen_ack !== 1'b0 || d_rdata_o !== 32'h0) begin
            fails++; $display("FAIL rstmid_late_ready: activity %b rdata %h want 0 00000000",
                              seen_ack, d_rdata_o);
        end
        if_req_i = 1'b1; if_addr_i = 32'h50;
        d_req_i = 1'b1; d_addr_i = 32'h404;
        tick();
        checks++;
        if (mem_addr_o !== 32'h404 || mem_req_o !== 1'b1) begin
            fails++; $display("FAIL rstmid_next_grant: addr %h req %b want 00000404 1", mem_addr_o, mem_req_o);
        end
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        d_req_i = 1'b0;
        tick();
        tick();
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        if_req_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_rdata_i = '0; mem_ready_i = 1'b0;
        test_reset();
        test_fetch();
        test_arbitration();
        test_back_to_back();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum wait in cycles for mem_ready_i.
REQ-002 The block SHALL have parameter ADDR_W, default 32: address width.
REQ-003 The block SHALL have parameter DATA_W, default 32: data width.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 if_req_i  in  1  instruction-fetch request, level, held until if_ack_o.
REQ-007 if_addr_i  in  ADDR_W  fetch address, stable while if_req_i is high.
REQ-008 if_rdata_o  out  DATA_W  fetched word, valid while if_ack_o is high.
REQ-009 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-010 d_req_i  in  1  data request, level, held until d_ack_o.
REQ-011 d_we_i  in  1  1 = write, 0 = read.
REQ-012 d_addr_i  in  ADDR_W  data address.
REQ-013 d_wdata_i  in  DATA_W  write data.
REQ-014 d_rdata_o  out  DATA_W  read data, valid while d_ack_o is high.
REQ-015 d_ack_o  out  1  one-cycle data completion pulse.
REQ-016 stall_o  out  1  pipeline freeze.
REQ-017 mem_req_o  out  1  unified-memory request, held until mem_ready_i.
REQ-018 mem_we_o  out  1  write strobe to memory.
REQ-019 mem_addr_o  out  ADDR_W  memory address.
REQ-020 mem_wdata_o  out  DATA_W  memory write data.
REQ-021 mem_rdata_i  in  DATA_W  memory read data, valid with mem_ready_i.
REQ-022 mem_ready_i  in  1  one-cycle memory completion.
REQ-023 err_o  out  1  sticky timeout flag.

Function
REQ-024 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE_I and DONE_D.
REQ-025 In IDLE with requests pending, the grant SHALL go to data unless last_grant = data and if_req_i = 1, in which case fetch SHALL be granted; last_grant SHALL update on every grant.
REQ-026 On a grant, address, we (0 for fetch) and wdata SHALL be registered; mem_req_o and the mem_* buses SHALL be driven from registers starting the next cycle (BUSY_x).
REQ-027 In BUSY_x, mem_req_o and the mem_* buses SHALL remain stable until mem_ready_i is sampled high.
REQ-028 On mem_ready_i in BUSY_x, mem_rdata_i SHALL be latched into x_rdata_o, mem_req_o SHALL drop, and the FSM SHALL go to DONE_x.
REQ-029 DONE_x SHALL assert x_ack_o for exactly one cycle, then the FSM SHALL return to IDLE; no grant is issued in DONE_x.
REQ-030 Minimum latency from request to ack SHALL be 3 cycles when mem_ready_i arrives 1 cycle after mem_req_o rises.
REQ-031 mem_ready_i in IDLE or DONE_x SHALL be ignored.
REQ-032 A wait counter SHALL clear on grant and increment each BUSY cycle without mem_ready_i.
REQ-033 If the wait counter reaches TIMEOUT, the block SHALL drop mem_req_o, latch 0 into x_rdata_o, set err_o, and go to DONE_x so that the requester still gets an ack.
REQ-034 err_o SHALL remain set until reset.
REQ-035 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).
REQ-036 x_rdata_o SHALL hold its last latched value outside ack cycles.
REQ-037 A request that is withdrawn before its grant SHALL be dropped silently.

Reset
REQ-038 On rst_i sampled high, including mid-transaction, the block SHALL set the state to IDLE, mem_req_o, mem_we_o, both acks and err_o to 0, mem_addr_o, mem_wdata_o and both rdata outputs to 0, the wait counter to 0, and last_grant to fetch.
REQ-039 An in-flight memory access SHALL be abandoned on reset; a late mem_ready_i SHALL be ignored.

Structure
REQ-040 Package mem_arb_pkg SHALL hold the FSM state enum and the default TIMEOUT, ADDR_W and DATA_W constants.
REQ-041 Sub-module arb_wait_counter SHALL provide the clear/enable/terminal-count counter; the counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-042 Fetch only, addr 0x40, mem_ready_i 2 cycles after mem_req_o, rdata 0x8C010004 -> if_ack_o pulses once 4 cycles after request, if_rdata_o = 0x8C010004, mem_we_o = 0.
REQ-043 if_req_i and d_req_i rise together, last_grant = fetch -> data is served first, then fetch, and stall_o stays high until if_ack_o.
REQ-044 Back-to-back data writes (0x100, 0x11111111) with if_req_i held -> fetch is granted before the second data access, and each mem_wdata_o matches its data.
REQ-045 mem_ready_i never asserted, TIMEOUT = 16 -> mem_req_o drops after 16 BUSY cycles, ack pulses with rdata 0, and err_o stays 1.
REQ-046 rst_i pulsed in BUSY_D -> mem_req_o = 0 the next cycle, no ack occurs, a late mem_ready_i is ignored, and the next grant is data.
